// File: rtl/mano_timing_control.sv
// Mano basic-computer sequencer: S flip-flop, sequence counter SC, one-hot T, opcode decode, phase strobes.
// Latency: start edge -> T0 in 1 cycle; ir sampled at the T2 edge -> d/i_bit valid from T3. No backpressure.
module mano_timing_control #(
   parameter int SC_WIDTH = 4,
   parameter int IR_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     halt,
   input  logic                     sc_clr,
   input  logic [IR_WIDTH-1:0]      ir,
   output logic [(2**SC_WIDTH)-1:0] t,
   output logic [7:0]               d,
   output logic                     i_bit,
   output logic                     running,
   output logic                     ind_cyc,
   output logic                     rr_exec,
   output logic                     io_exec,
   output logic                     sc_ovf
);

   localparam int T_WIDTH = 2**SC_WIDTH;
   localparam logic [T_WIDTH-1:0]  T_ONE  = {{(T_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [SC_WIDTH-1:0] SC_ONE = {{(SC_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [SC_WIDTH-1:0] SC_MAX = '1;

   typedef enum logic {
      ST_STOP = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t              state_q;
   state_t              state_nxt;
   logic [SC_WIDTH-1:0] sc_q;
   logic [SC_WIDTH-1:0] sc_nxt;
   logic                sc_ovf_q;
   logic                sc_ovf_nxt;
   logic [7:0]          d_q;
   logic                i_bit_q;
   logic [2:0]          opcode;
   logic                op_capture;
   logic                ir_unused;

   assign opcode    = ir[IR_WIDTH-2 -: 3];
   assign ir_unused = ^ir[IR_WIDTH-5:0];

   // Next-state: halt outranks sc_clr, which outranks the normal increment.
   always_comb begin
      state_nxt  = state_q;
      sc_nxt     = sc_q;
      sc_ovf_nxt = sc_ovf_q;
      case (state_q)
         ST_STOP: begin
            sc_nxt = '0;
            if (start) begin
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (halt) begin
               state_nxt = ST_STOP;
               sc_nxt    = '0;
            end else if (sc_clr) begin
               sc_nxt = '0;
            end else begin
               sc_nxt = sc_q + SC_ONE;
               if (sc_q == SC_MAX) begin
                  sc_ovf_nxt = 1'b1;
               end
            end
         end
         default: begin
            state_nxt = ST_STOP;
            sc_nxt    = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_STOP;
         sc_q     <= '0;
         sc_ovf_q <= 1'b0;
         d_q      <= '0;
         i_bit_q  <= 1'b0;
      end else begin
         state_q  <= state_nxt;
         sc_q     <= sc_nxt;
         sc_ovf_q <= sc_ovf_nxt;
         // Capture happens at the end of T2 regardless of halt/sc_clr on that edge.
         if (op_capture) begin
            d_q     <= 8'd1 << opcode;
            i_bit_q <= ir[IR_WIDTH-1];
         end
      end
   end

   assign running = (state_q == ST_RUN);

   always_comb begin
      t = '0;
      if (running) begin
         t = T_ONE << sc_q;
      end
   end

   assign op_capture = t[2];

   assign d       = d_q;
   assign i_bit   = i_bit_q;
   assign sc_ovf  = sc_ovf_q;

   // t[3] is already zero while stopped, so the strobes need no extra gating.
   assign ind_cyc = t[3] & ~d_q[7] &  i_bit_q;
   assign rr_exec = t[3] &  d_q[7] & ~i_bit_q;
   assign io_exec = t[3] &  d_q[7] &  i_bit_q;

endmodule
